// File: rtl/hamming7_arbiter_pkg.sv
// Shared definitions for the two-requester Hamming(7,4) checking front end.
// Holds the FSM encoding, widths and the round-robin grant rule.
package hamming7_arbiter_pkg;

  localparam int CW_W = 7;
  localparam int NREQ = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  typedef logic [CW_W:1] cw_t;

  // A lone requester always wins; a tie goes to whoever was not served last.
  function automatic logic arb_pick(input logic [NREQ-1:0] req, input logic last);
    logic pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/hamming7_arbiter_hamming7check.sv
// Combinational Hamming(7,4) single-error corrector, positions 1,2,4 are parity.
// A nonzero syndrome names the bit position to flip.
module hamming7check
  import hamming7_arbiter_pkg::*;
(
  input  logic [CW_W:1] DU,
  output logic [CW_W:1] DC,
  output logic          NOERROR
);

  logic [2:0]    syn;
  logic [CW_W:1] flip;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    flip    = '0;
    syn[0]  = DU[1] ^ DU[3] ^ DU[5] ^ DU[7];
    syn[1]  = DU[2] ^ DU[3] ^ DU[6] ^ DU[7];
    syn[2]  = DU[4] ^ DU[5] ^ DU[6] ^ DU[7];
    for (int i = 1; i <= CW_W; i++) begin
      flip[i] = (syn == 3'(i));
    end
    DC      = DU ^ flip;
    NOERROR = (syn == 3'd0);
  end

endmodule

// File: rtl/hamming7_arbiter.sv
// Round-robin front end sharing one hamming7check between two codeword sources,
// with a registered one-cycle acknowledge and a saturating corrected-word count.
module hamming7_arbiter
  import hamming7_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NREQ-1:0]  REQ,
  input  logic [CW_W:1]    DU0,
  input  logic [CW_W:1]    DU1,
  input  logic             CLRCNT,
  output logic [NREQ-1:0]  ACK,
  output logic             VALID,
  output logic             GID,
  output logic [CW_W:1]    DC,
  output logic             NOERR,
  output logic [CNT_W-1:0] ERRCNT
);

  logic [1:0] state;
  cw_t        dur;
  logic       last;
  logic       grant;
  cw_t        dec_dc;
  logic       dec_noerr;

  assign grant = arb_pick(REQ, last);

  // The decoder only ever sees the registered word, never DU0/DU1 directly.
  hamming7check u_check (
    .DU      (dur),
    .DC      (dec_dc),
    .NOERROR (dec_noerr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      dur   <= '0;
      last  <= 1'b1;
      GID   <= 1'b0;
      ACK   <= '0;
      VALID <= 1'b0;
      DC    <= '0;
      NOERR <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (REQ != '0) begin
            dur   <= grant ? DU1 : DU0;
            GID   <= grant;
            last  <= grant;
            state <= CHECK;
          end
        end
        CHECK: begin
          DC    <= dec_dc;
          NOERR <= dec_noerr;
          ACK   <= {GID, ~GID};
          VALID <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          ACK   <= '0;
          VALID <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear has priority over the increment that lands on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERRCNT <= '0;
    end else if (CLRCNT) begin
      ERRCNT <= '0;
    end else if (state == CHECK && !dec_noerr && ERRCNT != '1) begin
      ERRCNT <= ERRCNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming7_arbiter.sv
// Randomized self-checking bench for hamming7_arbiter against a nearest-codeword
// reference model and a plain round-robin / saturating-counter model.
module tb_hamming7_arbiter;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [1:0]       REQ;
  logic [7:1]       DU0, DU1;
  logic             CLRCNT;
  logic [1:0]       ACK;
  logic             VALID, GID, NOERR;
  logic [7:1]       DC;
  logic [CNT_W-1:0] ERRCNT;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic m_last;
  int   m_cnt;
  bit   held;

  hamming7_arbiter #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DU0(DU0), .DU1(DU1), .CLRCNT(CLRCNT),
    .ACK(ACK), .VALID(VALID), .GID(GID), .DC(DC), .NOERR(NOERR), .ERRCNT(ERRCNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Hamming(7,4) encoder: data at positions 7,6,5,3, even parity at 4,2,1.
  function automatic logic [7:1] enc(input logic [3:0] n);
    logic [7:1] c;
    c    = '0;
    c[3] = n[0]; c[5] = n[1]; c[6] = n[2]; c[7] = n[3];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  // The code is perfect: every 7-bit word lies within distance 1 of exactly one codeword.
  task automatic ref_decode(input logic [7:1] w, output logic [7:1] dc, output logic noerr);
    dc    = '0;
    noerr = 1'b0;
    for (int n = 0; n < 16; n++) begin
      logic [7:1] c;
      c = enc(4'(n));
      if ($countones(c ^ w) <= 1) begin
        dc    = c;
        noerr = (c == w);
      end
    end
  endtask

  function automatic logic [7:1] corrupt(input logic [7:1] c, input int flips);
    logic [7:1] w;
    w = c;
    for (int k = 0; k < flips; k++) w[$urandom_range(7, 1)] ^= 1'b1;
    return w;
  endfunction

  // One transaction, entered and left at a negedge. Latency counts rising edges
  // from the input change to the edge that raises ACK.
  task automatic run_txn(input string tag, input logic [1:0] req, input logic [7:1] w0,
                         input logic [7:1] w1, input bit clr_on_ack, input bit drop_after);
    logic       g, e_noerr;
    logic [7:1] e_dc;
    int         exp_lat, lat;
    bit         got;
    exp_lat = held ? 3 : 2;
    g       = (req == 2'b01) ? 1'b0 : (req == 2'b10) ? 1'b1 : ~m_last;
    m_last  = g;
    ref_decode(g ? w1 : w0, e_dc, e_noerr);
    if (clr_on_ack) m_cnt = 0;
    else if (!e_noerr && m_cnt < CNT_MAX) m_cnt++;

    REQ = req; DU0 = w0; DU1 = w1;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      if (clr_on_ack && i == exp_lat) CLRCNT = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      CLRCNT = 1'b0;
      if (VALID) begin
        got = 1;
        lat = i;
      end else begin
        check({tag, "_ack_idle"}, 32'(ACK), 32'd0);
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_lat"},    32'(lat),    32'(exp_lat));
      check({tag, "_ack"},    32'(ACK),    g ? 32'd2 : 32'd1);
      check({tag, "_gid"},    32'(GID),    32'(g));
      check({tag, "_dc"},     32'(DC),     32'(e_dc));
      check({tag, "_noerr"},  32'(NOERR),  32'(e_noerr));
      check({tag, "_errcnt"}, 32'(ERRCNT), 32'(m_cnt));
    end
    held = !drop_after;
    if (drop_after) begin
      REQ = 2'b00;
      @(posedge CLK);
      @(negedge CLK);
      check({tag, "_pulse"}, {31'd0, VALID} | 32'(ACK), 32'd0);
      check({tag, "_hold"},  32'(DC),   32'(e_dc));
    end
  endtask

  initial begin
    logic [7:1] w0, w1;
    logic [1:0] rq;
    RST_N  = 1'b0;
    REQ    = 2'b00;
    DU0    = '0;
    DU1    = '0;
    CLRCNT = 1'b0;
    m_last = 1'b1;
    m_cnt  = 0;
    held   = 0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ack",    32'(ACK),    32'd0);
    check("rst_valid",  32'(VALID),  32'd0);
    check("rst_gid",    32'(GID),    32'd0);
    check("rst_dc",     32'(DC),     32'd0);
    check("rst_noerr",  32'(NOERR),  32'd1);
    check("rst_errcnt", 32'(ERRCNT), 32'd0);
    RST_N = 1'b1;

    run_txn("clean",  2'b01, 7'b1010101, 7'b0000000, 0, 1);
    run_txn("single", 2'b10, 7'b0000000, 7'b1010001, 0, 1);

    // Every single-bit error of every codeword corrects; count lands on 112.
    CLRCNT = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CLRCNT = 1'b0;
    m_cnt  = 0;
    check("clr_direct", 32'(ERRCNT), 32'd0);
    for (int n = 0; n < 16; n++) begin
      for (int p = 1; p <= 7; p++) begin
        w1 = enc(4'(n));
        w1[p] = ~w1[p];
        run_txn("exh", 2'b10, 7'b0, w1, 0, 1);
      end
    end
    check("exh_total", 32'(ERRCNT), 32'd112);

    // Held tie alternates grants, three cycles per answer.
    for (int i = 0; i < 4; i++) begin
      run_txn("tie", 2'b11, 7'b0000000, 7'b1010101, 0, i == 3);
    end

    for (int i = 0; i < 60; i++) begin
      rq = 2'($urandom_range(3, 1));
      w0 = corrupt(enc(4'($urandom_range(15))), $urandom_range(2));
      w1 = corrupt(enc(4'($urandom_range(15))), $urandom_range(2));
      run_txn("rand", rq, w0, w1, 0, bit'($urandom_range(1)));
    end
    if (held) run_txn("rand_end", 2'b01, enc(4'd9), 7'b0, 0, 1);

    // Saturation: clear, then 260 erroneous words.
    run_txn("sat_clr", 2'b01, enc(4'd3), 7'b0, 1, 1);
    for (int i = 0; i < 260; i++) begin
      w0 = corrupt(enc(4'($urandom_range(15))), 0);
      w0[$urandom_range(7, 1)] ^= 1'b1;
      run_txn("sat", 2'b01, w0, 7'b0, 0, 1);
    end
    check("sat_final", 32'(ERRCNT), 32'(CNT_MAX));

    // Clear coinciding with an increment wins.
    run_txn("clr_inc", 2'b10, 7'b0, 7'b1110101, 1, 1);

    // Build a nonzero count, then reset in the middle of a transaction.
    run_txn("pre_rst", 2'b10, 7'b0, 7'b0110011, 0, 1);
    REQ = 2'b10;
    DU0 = 7'b0;
    DU1 = 7'b1011010;
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("midrst_ack",    32'(ACK),    32'd0);
    check("midrst_valid",  32'(VALID),  32'd0);
    check("midrst_gid",    32'(GID),    32'd0);
    check("midrst_dc",     32'(DC),     32'd0);
    check("midrst_noerr",  32'(NOERR),  32'd1);
    check("midrst_errcnt", 32'(ERRCNT), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("midrst_noack", 32'(ACK), 32'd0);
    RST_N  = 1'b1;
    m_last = 1'b1;
    m_cnt  = 0;
    held   = 0;
    run_txn("post_rst", 2'b10, 7'b0, 7'b1011010, 0, 1);

    // No request, no response.
    REQ = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("idle_valid", 32'(VALID), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
